// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver feeding a show-ahead receive FIFO.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   reset        synchronous active-high reset, clears all state
//   RXD          asynchronous serial input, idle high
//   rd_en        pop the head entry when rd_valid is set
//   rd_data      head entry data (show-ahead)
//   rd_perr      head entry parity error (always 0 without parity)
//   rd_ferr      head entry framing error
//   rd_valid     FIFO not empty
//   fifo_count   number of stored entries
//   overrun      sticky: a completed frame was dropped because the FIFO was full
//   clr_overrun  clears overrun (a same-cycle set wins)
//   busy         receiver is not idle
module uart_rx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          RXD,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_perr,
    output logic                          rd_ferr,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    input  logic                          clr_overrun,
    output logic                          busy
);

    localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW   = $clog2(DATA_BITS + 1);
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNTW = AW + 1;
    localparam int unsigned EW   = DATA_BITS + 2;

    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    // ---------------- input synchroniser ----------------
    logic [1:0] r_sync;
    logic [1:0] r_sync_vld;
    logic       w_rxs;

    assign w_rxs = r_sync[1];

    // r_sync_vld marks when w_rxs carries a real pin sample rather than the reset value
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync     <= 2'b11;
            r_sync_vld <= 2'b00;
        end else begin
            r_sync     <= {r_sync[0], RXD};
            r_sync_vld <= {r_sync_vld[0], 1'b1};
        end
    end

    // ---------------- receiver FSM ----------------
    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [BW-1:0]        r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_armed;
    logic                 r_busy;

    logic                 w_tick;
    logic                 w_frame_done;
    logic                 w_frame_ferr;

    assign w_tick       = (r_cnt == LAST);
    assign w_frame_done = (r_state == S_STOP) && w_tick && (r_bit == BW'(STOP_BITS - 1));
    assign w_frame_ferr = r_ferr | ~w_rxs;

    // Bit timing: start checked at half-bit, then every CLKS_PER_BIT cycles from there
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_armed <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    r_bit <= '0;
                    // after reset, only a line seen high may start a frame
                    if (w_rxs && r_sync_vld[1]) begin
                        r_armed <= 1'b1;
                    end
                    if (!w_rxs && r_armed) begin
                        r_state <= S_START;
                        r_busy  <= 1'b1;
                        r_perr  <= 1'b0;
                        r_ferr  <= 1'b0;
                    end
                end
                S_START: begin
                    if (r_cnt == HALF_M1) begin
                        r_cnt <= '0;
                        if (w_rxs) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
                        if (r_bit == BW'(DATA_BITS - 1)) begin
                            r_bit   <= '0;
                            r_state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            r_bit <= r_bit + BW'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_PARITY: begin
                    if (w_tick) begin
                        r_cnt   <= '0;
                        r_perr  <= ((^r_shift) ^ w_rxs) != (PARITY == 2);
                        r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        r_cnt <= '0;
                        if (w_frame_done) begin
                            r_bit <= '0;
                            if (w_rxs) begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state <= S_WAIT_IDLE;
                            end
                        end else begin
                            r_bit <= r_bit + BW'(1);
                            if (!w_rxs) begin
                                r_ferr <= 1'b1;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_WAIT_IDLE: begin
                    // a held-low line yields one framing-error entry, not a stream
                    if (w_rxs) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // ---------------- receive FIFO ----------------
    logic [EW-1:0]        r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [CNTW-1:0]      r_count;
    logic [DATA_BITS-1:0] r_rd_data;
    logic                 r_rd_perr;
    logic                 r_rd_ferr;
    logic                 r_rd_valid;
    logic                 r_overrun;

    logic [EW-1:0]        w_wdata;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;
    logic [AW-1:0]        w_rd_ptr_n;
    logic [CNTW-1:0]      w_count_n;
    logic [EW-1:0]        w_head_n;

    assign w_wdata    = {r_shift, r_perr, w_frame_ferr};
    assign w_full     = (r_count == CNTW'(FIFO_DEPTH));
    assign w_pop      = rd_en && (r_count != '0);
    assign w_push     = w_frame_done && (!w_full || w_pop);
    assign w_drop     = w_frame_done && w_full && !w_pop;
    assign w_rd_ptr_n = r_rd_ptr + AW'(w_pop);

    // Next head: a write landing in the head slot bypasses the memory
    always_comb begin
        w_count_n = r_count;
        if (w_push && !w_pop) begin
            w_count_n = r_count + CNTW'(1);
        end else if (!w_push && w_pop) begin
            w_count_n = r_count - CNTW'(1);
        end
        w_head_n = r_mem[w_rd_ptr_n];
        if (w_push && (r_wr_ptr == w_rd_ptr_n)) begin
            w_head_n = w_wdata;
        end
    end

    // Storage, pointers and registered show-ahead head
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_data  <= '0;
            r_rd_perr  <= 1'b0;
            r_rd_ferr  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_wdata;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr                            <= w_rd_ptr_n;
            r_count                             <= w_count_n;
            {r_rd_data, r_rd_perr, r_rd_ferr}   <= w_head_n;
            r_rd_valid                          <= (w_count_n != '0);
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign rd_data    = r_rd_data;
    assign rd_perr    = r_rd_perr;
    assign rd_ferr    = r_rd_ferr;
    assign rd_valid   = r_rd_valid;
    assign fifo_count = r_count;
    assign overrun    = r_overrun;
    assign busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: bench for uart_rx_fifo.
// Main instance (8N1, 87 clocks/bit, depth 4) is checked every cycle against a
// frame-level queue model; parity and 5-bit/2-stop builds use directed checks.
module tb_uart_rx_fifo;

    localparam int unsigned CPB_M   = 87;
    localparam int unsigned HALF_M  = CPB_M / 2;
    localparam int unsigned DEPTH_M = 4;
    localparam int unsigned CPB_S   = 16;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } ent_t;

    typedef struct {
        int   at;
        ent_t e;
    } pend_t;

    logic clk = 1'b0;
    always #50 clk = ~clk;

    logic reset;

    // main 8N1 instance
    logic       rxd_m, rd_en_m, clr_m;
    logic [7:0] data_m;
    logic       perr_m, ferr_m, valid_m, ovr_m, busy_m;
    logic [2:0] count_m;

    // even / odd parity instances share one line
    logic       rxd_p, rd_en_p;
    logic [7:0] data_e, data_o;
    logic       perr_e, ferr_e, valid_e, ovr_e, busy_e;
    logic       perr_o, ferr_o, valid_o, ovr_o, busy_o;
    logic [2:0] count_e, count_o;

    // 5 data bits, 2 stop bits
    logic       rxd_5, rd_en_5;
    logic [4:0] data_5;
    logic       perr_5, ferr_5, valid_5, ovr_5, busy_5;
    logic [1:0] count_5;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB_M), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH_M)) u_m (
        .clk(clk), .reset(reset), .RXD(rxd_m), .rd_en(rd_en_m),
        .rd_data(data_m), .rd_perr(perr_m), .rd_ferr(ferr_m), .rd_valid(valid_m),
        .fifo_count(count_m), .overrun(ovr_m), .clr_overrun(clr_m), .busy(busy_m)
    );

    uart_rx_fifo #(.CLKS_PER_BIT(CPB_S), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_e (
        .clk(clk), .reset(reset), .RXD(rxd_p), .rd_en(rd_en_p),
        .rd_data(data_e), .rd_perr(perr_e), .rd_ferr(ferr_e), .rd_valid(valid_e),
        .fifo_count(count_e), .overrun(ovr_e), .clr_overrun(1'b0), .busy(busy_e)
    );

    uart_rx_fifo #(.CLKS_PER_BIT(CPB_S), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_o (
        .clk(clk), .reset(reset), .RXD(rxd_p), .rd_en(rd_en_p),
        .rd_data(data_o), .rd_perr(perr_o), .rd_ferr(ferr_o), .rd_valid(valid_o),
        .fifo_count(count_o), .overrun(ovr_o), .clr_overrun(1'b0), .busy(busy_o)
    );

    uart_rx_fifo #(.CLKS_PER_BIT(CPB_S), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(2)) u_5 (
        .clk(clk), .reset(reset), .RXD(rxd_5), .rd_en(rd_en_5),
        .rd_data(data_5), .rd_perr(perr_5), .rd_ferr(ferr_5), .rd_valid(valid_5),
        .fifo_count(count_5), .overrun(ovr_5), .clr_overrun(1'b0), .busy(busy_5)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    logic chk_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // ---------------- frame-level model of the main instance ----------------
    ent_t  q[$];
    pend_t pend[$];
    logic  m_ovr = 1'b0;
    int    m_sz;
    logic  m_pop, m_wr;

    // A frame whose start bit hits the pin in cycle p completes on edge
    // p + 2 (synchroniser) + half bit + 9 bit periods + 1.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (reset) begin
            q.delete();
            pend.delete();
            m_ovr = 1'b0;
        end else begin
            m_sz  = q.size();
            m_pop = rd_en_m && (m_sz != 0);
            m_wr  = (pend.size() != 0) && (pend[0].at == cyc);
            if (m_pop) void'(q.pop_front());
            if (m_wr) begin
                if (m_sz == int'(DEPTH_M) && !m_pop) m_ovr = 1'b1;
                else q.push_back(pend[0].e);
                void'(pend.pop_front());
            end
            if (clr_m && !(m_wr && m_sz == int'(DEPTH_M) && !m_pop)) m_ovr = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            chk("m_valid", 32'(valid_m), 32'(q.size() != 0));
            chk("m_count", 32'(count_m), 32'(q.size()));
            chk("m_overrun", 32'(ovr_m), 32'(m_ovr));
            if (q.size() != 0) begin
                chk("m_data", 32'(data_m), 32'(q[0].d));
                chk("m_perr", 32'(perr_m), 32'(q[0].pe));
                chk("m_ferr", 32'(ferr_m), 32'(q[0].fe));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input int sel, input int cpb, input logic [15:0] bits, input int nb);
        for (int i = 0; i < nb; i++) begin
            case (sel)
                0:       rxd_m = bits[i];
                1:       rxd_p = bits[i];
                default: rxd_5 = bits[i];
            endcase
            tick(cpb);
        end
    endtask

    task automatic send_m(input logic [7:0] dat, input logic stopv);
        pend_t p;
        p.at = cyc + 2 + int'(HALF_M) + 9 * int'(CPB_M) + 1;
        p.e  = '{d: dat, pe: 1'b0, fe: ~stopv};
        pend.push_back(p);
        send_bits(0, CPB_M, {6'h0, stopv, dat, 1'b0}, 10);
    endtask

    task automatic pop_m();
        rd_en_m = 1'b1;
        tick(1);
        rd_en_m = 1'b0;
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    int w_edge;

    initial begin
        reset = 1'b1;
        rxd_m = 1'b1; rxd_p = 1'b1; rxd_5 = 1'b1;
        rd_en_m = 1'b0; rd_en_p = 1'b0; rd_en_5 = 1'b0; clr_m = 1'b0;
        tick(3);
        reset  = 1'b0;
        chk_en = 1'b1;
        tick(1);
        chk("rst_valid", 32'(valid_m), 0);
        chk("rst_count", 32'(count_m), 0);
        chk("rst_overrun", 32'(ovr_m), 0);
        chk("rst_busy", 32'(busy_m), 0);
        chk("rst_data", 32'(data_m), 0);
        chk("rst_valid_e", 32'(valid_e), 0);
        chk("rst_valid_5", 32'(valid_5), 0);

        // parity: 0x55 has four ones; parity bit 1 -> odd total
        send_bits(1, CPB_S, {5'h0, 1'b1, 1'b1, 8'h55, 1'b0}, 11);
        tick(4);
        chk("par1_even_perr", 32'(perr_e), 1);
        chk("par1_odd_perr", 32'(perr_o), 0);
        chk("par1_even_data", 32'(data_e), 32'h55);
        chk("par1_odd_data", 32'(data_o), 32'h55);
        chk("par1_ferr", 32'(ferr_e | ferr_o), 0);
        rd_en_p = 1'b1; tick(1); rd_en_p = 1'b0;
        send_bits(1, CPB_S, {5'h0, 1'b1, 1'b0, 8'h55, 1'b0}, 11);
        tick(4);
        chk("par0_even_perr", 32'(perr_e), 0);
        chk("par0_odd_perr", 32'(perr_o), 1);
        chk("par0_count", 32'(count_e), 1);
        chk("par0_count_o", 32'(count_o), 1);
        rd_en_p = 1'b1; tick(1); rd_en_p = 1'b0;
        chk("par_drained", 32'(valid_e | valid_o | ovr_e | ovr_o | busy_e | busy_o), 0);

        // 5 data bits, 2 stop bits
        send_bits(2, CPB_S, {8'h0, 2'b11, 5'h15, 1'b0}, 8);
        tick(4);
        chk("d5_data", 32'(data_5), 32'h15);
        chk("d5_errs", 32'({perr_5, ferr_5}), 0);
        chk("d5_count", 32'(count_5), 1);
        rd_en_5 = 1'b1; tick(1); rd_en_5 = 1'b0;
        send_bits(2, CPB_S, {8'h0, 1'b0, 1'b1, 5'h0A, 1'b0}, 8);
        rxd_5 = 1'b1;
        tick(4);
        chk("d5_stop2_ferr", 32'(ferr_5), 1);
        chk("d5_stop2_data", 32'(data_5), 32'h0A);
        chk("d5_busy_ovr", 32'({busy_5, ovr_5}), 0);

        // 8N1 back-to-back frames starting near 8600 ns
        while (cyc < 86) tick(1);
        send_m(8'h3F, 1'b1);
        send_m(8'h55, 1'b1);
        tick(5);
        chk("b2b_count", 32'(count_m), 2);
        chk("b2b_head", 32'(data_m), 32'h3F);
        pop_m();
        chk("b2b_second", 32'(data_m), 32'h55);
        pop_m();
        chk("b2b_empty", 32'(valid_m), 0);

        // 20-cycle glitch is shorter than half a bit
        rxd_m = 1'b0;
        tick(15);
        chk("glitch_busy", 32'(busy_m), 1);
        tick(5);
        rxd_m = 1'b1;
        tick(100);
        chk("glitch_idle", 32'(busy_m), 0);
        chk("glitch_noentry", 32'(valid_m), 0);

        // stop bit low then break for 3 bit times
        send_m(8'hA5, 1'b0);
        tick(CPB_M);
        chk("brk_busy", 32'(busy_m), 1);
        chk("brk_ferr", 32'(ferr_m), 1);
        chk("brk_data", 32'(data_m), 32'hA5);
        tick(2 * CPB_M);
        rxd_m = 1'b1;
        tick(10);
        chk("brk_released", 32'(busy_m), 0);
        chk("brk_one_entry", 32'(count_m), 1);
        pop_m();
        tick(2 * CPB_M);
        chk("brk_no_more", 32'(valid_m), 0);

        // overrun: 5 frames into depth 4
        for (int i = 1; i <= 5; i++) send_m(8'(i), 1'b1);
        tick(5);
        chk("ovr_set", 32'(ovr_m), 1);
        chk("ovr_count", 32'(count_m), 4);
        chk("ovr_head", 32'(data_m), 32'h01);
        clr_m = 1'b1; tick(1); clr_m = 1'b0;
        chk("ovr_clr", 32'(ovr_m), 0);

        // full FIFO, pop on the same edge as the write of 0x06
        fork
            send_m(8'h06, 1'b1);
            begin
                w_edge = cyc + 2 + int'(HALF_M) + 9 * int'(CPB_M) + 1;
                tick(w_edge - 1 - cyc);
                rd_en_m = 1'b1;
                tick(1);
                rd_en_m = 1'b0;
            end
        join
        tick(5);
        chk("popwr_count", 32'(count_m), 4);
        chk("popwr_ovr", 32'(ovr_m), 0);
        chk("popwr_head", 32'(data_m), 32'h02);
        send_m(8'h07, 1'b1);
        tick(5);
        chk("ovr_again", 32'(ovr_m), 1);

        // reset in the middle of the data bits
        send_bits(0, CPB_M, {12'h0, 3'b101, 1'b0}, 4);
        rxd_m = 1'b0;
        tick(40);
        chk("mid_busy", 32'(busy_m), 1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        rxd_m = 1'b1;
        chk("mrst_valid", 32'(valid_m), 0);
        chk("mrst_count", 32'(count_m), 0);
        chk("mrst_overrun", 32'(ovr_m), 0);
        chk("mrst_busy", 32'(busy_m), 0);
        chk("mrst_data", 32'(data_m), 0);
        chk("mrst_flags", 32'({perr_m, ferr_m}), 0);
        tick(2 * CPB_M);
        send_m(8'h3C, 1'b1);
        tick(5);
        chk("after_rst_data", 32'(data_m), 32'h3C);
        chk("after_rst_count", 32'(count_m), 1);
        pop_m();
        tick(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with integrated receive FIFO. It replaces the fixed 8N1 receive path behind the SOC UART (`RXD` pin) and adds configurable frame format, per-byte parity and framing error flags, and overrun detection. It oversamples `RXD` with the system clock and delivers bytes through a show-ahead FIFO to the CPU-side register interface.

## Interface
- `CLKS_PER_BIT`, 87 — system clocks per UART bit (10 MHz / 115200); minimum 8.
- `DATA_BITS`, 8 — data bits per frame, 5..9, LSB first.
- `PARITY`, 0 — 0 none, 1 even, 2 odd.
- `STOP_BITS`, 1 — 1 or 2.
- `FIFO_DEPTH`, 4 — entries; power of two, ≥2.

- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `RXD`  in  1  asynchronous serial input, idle high.
- `rd_en`  in  1  pop head entry when `rd_valid`=1.
- `rd_data`  out  DATA_BITS  head entry data (show-ahead).
- `rd_perr`  out  1  head entry parity error (0 when PARITY=0).
- `rd_ferr`  out  1  head entry framing error.
- `rd_valid`  out  1  FIFO not empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  stored entries.
- `overrun`  out  1  sticky: a completed frame was dropped because FIFO full.
- `clr_overrun`  in  1  clears `overrun`.
- `busy`  out  1  receiver not in IDLE.

## Operation
- `RXD` passes a 2-FF synchroniser (`rxs`); all decisions use `rxs`. Synchroniser resets to 1.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE: `rxs`=0 → START, bit counter cleared. `busy`=0 only here.
- START: at half-bit point, `rxs`=1 → IDLE (false start, nothing stored); `rxs`=0 → DATA.
- DATA: sample one bit per CLKS_PER_BIT cycles into shift register, LSB first; after DATA_BITS samples → PARITY if PARITY≠0 else STOP.
- PARITY: sample; perr = (XOR of data bits XOR sampled bit) ≠ (PARITY==2 ? 1 : 0) ... i.e. even: total ones including parity bit must be even; odd: must be odd.
- STOP: sample STOP_BITS bits; ferr=1 if any sampled stop bit is 0. After final stop sample: write {data, perr, ferr} to FIFO; next state IDLE if `rxs`=1, else WAIT_IDLE.
- WAIT_IDLE: stay until `rxs`=1, then IDLE (a break or stuck-low line produces exactly one ferr entry, not a stream).
- FIFO: write on final stop sample edge. Full and write without same-cycle pop → entry dropped, `overrun` set. Full with simultaneous pop and write → both succeed, no overrun. `rd_en` while empty ignored.
- `overrun`: set beats `clr_overrun` in the same cycle.
- Reset values: `rd_valid`=0, `fifo_count`=0, `overrun`=0, `busy`=0, `rd_data`/`rd_perr`/`rd_ferr`=0, state IDLE. Reset mid-frame discards the partial frame; reception resumes at the next start edge after `rxs` is seen high.

## Timing
- Pin-to-`rxs` latency: 2 cycles.
- Let T0 = first cycle `rxs`=0 in IDLE. Start check at T0 + CLKS_PER_BIT/2 (floor). Bit k (k=0 first data bit, counting parity and stop bits sequentially) sampled at T0 + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT.
- Sample counter width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1, no drift across the frame.
- FIFO written on the edge of the final stop sample; `rd_valid`/`fifo_count` reflect it the next cycle.
- Pop: `rd_en`&`rd_valid` at edge E → next entry (or `rd_valid`=0) visible after E.
- Back-to-back frames: a start edge is accepted the cycle after the STOP→IDLE transition; frames with zero inter-frame idle beyond the stop bit are received without loss.

## Test plan
- 8N1, CLKS_PER_BIT=87: send 0x3F then 0x55 (start bit 8600 ns) → two entries 0x3F, 0x55, perr=ferr=0, `fifo_count`=2; two pops → `rd_valid`=0.
- PARITY=1, send 0x55 with parity bit 1 → `rd_perr`=1, data 0x55; with parity 0 → `rd_perr`=0. PARITY=2 inverts both results.
- Stop bit forced 0 on 0xA5, line held low 3 bit-times → one entry 0xA5 with ferr=1, `busy` high until line returns high; no further entries.
- Low glitch of 20 cycles on idle `RXD` → state returns to IDLE, no entry, `overrun`=0.
- FIFO_DEPTH=4: send 0x01..0x05 without reads → entries 0x01..0x04, `overrun`=1; `clr_overrun` → 0; full with pop coinciding with write of 0x06 → no overrun, `fifo_count` stays 4.
- Assert `reset` mid-data of a frame → all outputs at reset values next cycle; following 0x3C frame received correctly; DATA_BITS=5, STOP_BITS=2 build receives 0x15 correctly.
